// File: rtl/thee_vco_cal_pkg.sv
// Shared types and helpers for the VCO calibration controller.
//   cal_state_e : controller state encoding
//   code_to_v   : maps a control code onto the linear VMIN..VMAX voltage range
package thee_vco_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DECIDE,
    DONE
  } cal_state_e;

  // Code 0 maps to vmin, all-ones maps to vmax, linear in between.
  function automatic real code_to_v(input int unsigned code, input real vmin,
                                    input real vmax, input int unsigned code_w);
    real full_scale;
    full_scale = (2.0 ** code_w) - 1.0;
    return vmin + real'(code) * (vmax - vmin) / full_scale;
  endfunction

endpackage

// File: rtl/thee_vco_cal_edge_cnt.sv
// thee_edge_cnt: synchronises the divided VCO clock into the clk domain,
// detects its rising edges and counts them with a saturating counter.
//   clk, rst_n : controller clock, synchronous active-low reset
//   vco_div    : asynchronous divided VCO clock
//   clr        : clears the count (wins over en)
//   en         : count rising edges only while high
//   cnt        : saturating rising-edge count
module thee_edge_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vco_div,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // sync_q[0], sync_q[1] form the synchroniser; sync_q[2] is the edge-detect delay
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise = sync_q[1] & ~sync_q[2];
  assign cnt  = cnt_q;

  always_comb begin
    sync_d = {sync_q[1:0], vco_div};
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/thee_vco_cal.sv
// thee_vco_cal: successive-approximation calibration of a VCO control code.
// Each trial code is applied, left to settle, and the divided VCO output is
// counted over a fixed window; the result is the largest code whose count
// does not exceed target_cnt.
//   clk, rst_n  : controller clock, synchronous active-low reset
//   start       : begin calibration (sampled only in IDLE)
//   target_cnt  : required edges per window, captured on accepted start
//   vco_div     : divided VCO clock (asynchronous)
//   busy, done  : in-progress flag, one-cycle completion pulse
//   ctrl_code   : code driven to the VCO, vctl its control voltage
//   cal_code    : last calibration result, meas_cnt last window count
module thee_vco_cal
  import thee_vco_cal_pkg::*;
#(
  parameter int unsigned CODE_W        = 8,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WIN_CYCLES    = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter real         VMIN          = -0.8,
  parameter real         VMAX          = 0.8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic              vco_div,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] ctrl_code,
  output real               vctl,
  output logic [CODE_W-1:0] cal_code,
  output logic [CNT_W-1:0]  meas_cnt
);

  localparam int unsigned IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [CODE_W-1:0] MID_CODE = CODE_W'(1) << (CODE_W - 1);

  cal_state_e        state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [CODE_W-1:0] result_q, result_d;
  logic [CODE_W-1:0] ctrl_code_q, ctrl_code_d;
  logic [CODE_W-1:0] cal_code_q, cal_code_d;
  logic [CNT_W-1:0]  meas_cnt_q, meas_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              cnt_clr;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CODE_W-1:0] bit_mask;
  logic [CODE_W-1:0] kept;

  thee_edge_cnt #(
    .CNT_W(CNT_W)
  ) u_edge_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .vco_div(vco_div),
    .clr    (cnt_clr),
    .en     (state_q == MEASURE),
    .cnt    (edge_cnt)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign ctrl_code = ctrl_code_q;
  assign cal_code  = cal_code_q;
  assign meas_cnt  = meas_cnt_q;
  assign vctl      = code_to_v(32'(ctrl_code_q), VMIN, VMAX, CODE_W);

  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    target_d     = target_q;
    result_d     = result_q;
    ctrl_code_d  = ctrl_code_q;
    cal_code_d   = cal_code_q;
    meas_cnt_d   = meas_cnt_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    cnt_clr      = 1'b0;
    bit_mask     = CODE_W'(1) << bit_idx_q;
    // Ties keep the trial bit: result is the largest code with count <= target.
    kept         = (edge_cnt > target_q) ? result_q : (result_q | bit_mask);

    case (state_q)
      IDLE: begin
        if (start) begin
          target_d     = target_cnt;
          bit_idx_d    = IDX_W'(CODE_W - 1);
          result_d     = '0;
          ctrl_code_d  = MID_CODE;
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          win_cnt_d    = '0;
          cnt_clr      = 1'b1;
          state_d      = MEASURE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      MEASURE: begin
        if (win_cnt_q == WIN_W'(WIN_CYCLES - 1)) begin
          win_cnt_d = '0;
          state_d   = DECIDE;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
        end
      end
      DECIDE: begin
        meas_cnt_d = edge_cnt;
        result_d   = kept;
        if (bit_idx_q != '0) begin
          bit_idx_d    = bit_idx_q - IDX_W'(1);
          ctrl_code_d  = kept | (CODE_W'(1) << (bit_idx_q - IDX_W'(1)));
          settle_cnt_d = '0;
          state_d      = SETTLE;
        end else begin
          ctrl_code_d = kept;
          cal_code_d  = kept;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_idx_q    <= '0;
      target_q     <= '0;
      result_q     <= '0;
      ctrl_code_q  <= MID_CODE;
      cal_code_q   <= MID_CODE;
      meas_cnt_q   <= '0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      target_q     <= target_d;
      result_q     <= result_d;
      ctrl_code_q  <= ctrl_code_d;
      cal_code_q   <= cal_code_d;
      meas_cnt_q   <= meas_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_thee_vco_cal.sv
// Bench for thee_vco_cal: a behavioural VCO (1..2 GHz over vctl -0.8..+0.8,
// divided by 128) feeds the default-parameter DUT; a second CNT_W=4 DUT is
// fed with clk/4 to exercise counter saturation. Time unit is 1 ps nominal.
module tb_thee_vco_cal;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WIN    = 1024;
  localparam int unsigned SET    = 16;
  localparam int unsigned LAT    = CODE_W * (SET + WIN + 1) + 1;
  localparam real VMIN    = -0.8;
  localparam real VMAX    = 0.8;
  localparam real FMIN_G  = 1.0;
  localparam real FMAX_G  = 2.0;
  localparam real DIV     = 128.0;
  localparam real CLK_PS  = 10000.0;
  localparam real EPS     = 0.02;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              start_s = 1'b0;
  logic [CNT_W-1:0]  target_cnt = '0;
  logic [3:0]        target_s = 4'd15;
  logic              vco_div = 1'b0;
  logic [1:0]        fast_ph = 2'd0;
  logic              vco_fast;

  logic              busy, done, busy_s, done_s;
  logic [CODE_W-1:0] ctrl_code, cal_code, ctrl_s, cal_s;
  logic [CNT_W-1:0]  meas_cnt;
  logic [3:0]        meas_s;
  real               vctl, vctl_s;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int done_s_cnt = 0;

  thee_vco_cal u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target_cnt(target_cnt),
    .vco_div(vco_div), .busy(busy), .done(done), .ctrl_code(ctrl_code),
    .vctl(vctl), .cal_code(cal_code), .meas_cnt(meas_cnt)
  );

  thee_vco_cal #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .target_cnt(target_s),
    .vco_div(vco_fast), .busy(busy_s), .done(done_s), .ctrl_code(ctrl_s),
    .vctl(vctl_s), .cal_code(cal_s), .meas_cnt(meas_s)
  );

  always #5000 clk = ~clk;

  always @(negedge clk) fast_ph <= fast_ph + 2'd1;
  assign vco_fast = fast_ph[1];

  always @(negedge clk) begin
    if (done)   done_cnt   <= done_cnt + 1;
    if (done_s) done_s_cnt <= done_s_cnt + 1;
  end

  // Behavioural VCO + divide-by-128: half period of divided clock in ps.
  initial begin
    forever begin
      real fg;
      fg = FMIN_G + (vctl - VMIN) / (VMAX - VMIN) * (FMAX_G - FMIN_G);
      if (fg < FMIN_G) fg = FMIN_G;
      #(DIV * 1000.0 / (2.0 * fg)) vco_div = ~vco_div;
    end
  end

  // Reference: ideal edges per window for a given code.
  function automatic real n_of(input int unsigned c);
    real v, fg;
    v  = VMIN + real'(c) * (VMAX - VMIN) / 255.0;
    fg = FMIN_G + (v - VMIN) / (VMAX - VMIN) * (FMAX_G - FMIN_G);
    return real'(WIN) * CLK_PS * fg / (1000.0 * DIV);
  endfunction

  // Largest code whose ideal count is below lim (or at/below when incl).
  function automatic int unsigned last_code(input real lim, input bit incl);
    int unsigned r;
    r = 0;
    for (int unsigned c = 0; c < 256; c++)
      if (incl ? (n_of(c) <= lim) : (n_of(c) < lim)) r = c;
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    n_vec++;
    if (act - exp > 1e-9 || exp - act > 1e-9) begin
      n_bad++;
      $display("FAIL %s: got %f, want %f", name, act, exp);
    end
  endtask

  task automatic run_cal(input logic [CNT_W-1:0] t, input bit with_sat, output int lat);
    @(negedge clk);
    start = 1'b1; target_cnt = t; start_s = with_sat;
    @(negedge clk);
    start = 1'b0; start_s = 1'b0; target_cnt = CNT_W'($urandom);
    lat = 1;
    chk("busy_after_start", busy, 1, 1);
    while (!done && lat < int'(LAT) + 50) begin
      // Extra start pulse and target change while busy must be ignored.
      start = (lat == 100);
      if (lat == 100) target_cnt = CNT_W'($urandom);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [CNT_W-1:0] target;
    int unsigned      lo;
    int unsigned      hi;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat, d0;
    int unsigned trial;
    real nt;

    tbl[0].target = 16'd120;
    tbl[1].target = 16'd0;
    tbl[2].target = 16'hFFFF;
    tbl[3].target = CNT_W'($urandom_range(95, 150));
    tbl[4].target = CNT_W'($urandom_range(85, 155));
    foreach (tbl[k]) begin
      tbl[k].lo = last_code(real'(tbl[k].target) - EPS, 1'b1);
      tbl[k].hi = last_code(real'(tbl[k].target) + 1.0 + EPS, 1'b0);
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0, 0);
    chk("rst_done", done, 0, 0);
    chk("rst_ctrl", ctrl_code, 128, 128);
    chk("rst_cal", cal_code, 128, 128);
    chk("rst_meas", meas_cnt, 0, 0);
    chk_r("rst_vctl", vctl, VMIN + 128.0 * (VMAX - VMIN) / 255.0);
    chk("rst_sat_busy", busy_s, 0, 0);
    rst_n = 1'b1;

    // Abort mid-calibration by reset
    @(negedge clk);
    start = 1'b1; target_cnt = 16'd120;
    @(negedge clk);
    start = 1'b0;
    repeat (2999) @(negedge clk);
    chk("abort_busy_before", busy, 1, 1);
    rst_n = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0, 0);
    chk("abort_ctrl", ctrl_code, 128, 128);
    chk("abort_cal", cal_code, 128, 128);
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0, 0);
    chk("abort_idle", busy, 0, 0);

    // Table of calibrations
    foreach (tbl[k]) begin
      d0 = done_cnt;
      run_cal(tbl[k].target, (k == 0), lat);
      chk("latency", lat, LAT, LAT);
      chk("busy_in_done", busy, 1, 1);
      @(negedge clk);
      chk("done_pulse_len", done, 0, 0);
      chk("busy_after_done", busy, 0, 0);
      chk("cal_code", cal_code, tbl[k].lo, tbl[k].hi);
      chk("ctrl_eq_cal", ctrl_code, cal_code, cal_code);
      chk_r("vctl", vctl, VMIN + real'(cal_code) * (VMAX - VMIN) / 255.0);
      trial = (int'(cal_code) & 32'hFE) | 1;
      nt = n_of(trial);
      chk("meas_cnt", meas_cnt, longint'($floor(nt - EPS)), longint'($ceil(nt + EPS)));
      chk("meas_vs_bit0", ((meas_cnt <= tbl[k].target) == cal_code[0]), 1, 1);
      repeat (3) @(negedge clk);
      chk("done_count", done_cnt - d0, 1, 1);
      if (k == 0) begin
        chk("sat_done", done_s_cnt, 1, 1);
        chk("sat_cal", cal_s, 255, 255);
        chk("sat_meas", meas_s, 15, 15);
        chk("sat_busy", busy_s, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
